// File: rtl/tri_bus_arb_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM state encoding and
// a width helper used to size the arbiter's counters.
package tri_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // Counter width for a count range of v values, never below one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tri_bus_arb_if.sv
// Requester-side bundle of the tri-state bus arbiter. The arbiter uses the
// slave view; the requesters (or a testbench) use the master view.
interface tri_bus_arb_if #(
    parameter int N = 3,
    parameter int M = 4
) ();
    logic [M-1:0]   req;
    logic [M-1:0]   done;
    logic [M*N-1:0] data_in;
    logic [M-1:0]   gnt;
    logic           bus_en;
    logic [N-1:0]   bus_data;
    logic           tout;

    modport master (
        output req, done, data_in,
        input  gnt, bus_en, bus_data, tout
    );

    modport slave (
        input  req, done, data_in,
        output gnt, bus_en, bus_data, tout
    );
endinterface

// File: rtl/tri_bus_arb_rr_pick.sv
// Round-robin selector: finds the first set request bit searching from
// last+1 upwards, wrapping modulo M. Purely combinational.
module tri_bus_arb_rr_pick #(
    parameter int M  = 4,
    parameter int LW = 2
) (
    input  logic [M-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] owner,
    output logic          valid
);

    // Scan candidates farthest-first so the nearest one after last wins.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        owner = '0;
        valid = 1'b0;
        for (int k = M; k >= 1; k--) begin
            if (req[LW'((int'(last) + k) % M)]) begin
                owner = LW'((int'(last) + k) % M);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arb.sv
// Round-robin arbiter and driver for a shared tri-state bus. Grants one
// requester at a time, drives its data slice onto bus_data and enforces a
// bus_en-low turnaround gap between owners.
// Optional hold limit: define TRI_BUS_TIMEOUT_EN to force release after
// HOLD_MAX cycles of ownership (tout pulses for one cycle).
module tri_bus_arb
    import tri_bus_arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int M        = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tri_bus_arb_if.slave  bus
);

    localparam int LW = clog2_min1(M);
    localparam int HW = clog2_min1(HOLD_MAX);
    localparam int TW = clog2_min1(TURN);

    state_e          state_q, state_d;
    logic [M-1:0]    gnt_q, gnt_d;
    logic            bus_en_q, bus_en_d;
    logic [LW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
    logic            tout_q, tout_d;

    logic [LW-1:0]   pick_owner;
    logic            pick_valid;
    logic            owner_release;
    logic            force_release;
    logic [N-1:0]    owner_data;

    tri_bus_arb_rr_pick #(.M(M), .LW(LW)) u_pick (
        .req   (bus.req),
        .last  (last_q),
        .owner (pick_owner),
        .valid (pick_valid)
    );

    // The current owner is always last_q while granted.
    always_comb begin
        owner_release = bus.done[last_q] || !bus.req[last_q];
`ifdef TRI_BUS_TIMEOUT_EN
        force_release = !owner_release && (hold_cnt_q == HW'(HOLD_MAX - 1));
`else
        force_release = 1'b0;
`endif
    end

    // Next-state and registered-output logic of the IDLE/GRANT/TURN FSM.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        bus_en_d   = bus_en_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        tout_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d      = {{(M-1){1'b0}}, 1'b1} << pick_owner;
                    bus_en_d   = 1'b1;
                    last_d     = pick_owner;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hold_cnt_q != HW'(HOLD_MAX - 1)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (owner_release || force_release) begin
                    gnt_d      = '0;
                    bus_en_d   = 1'b0;
                    turn_cnt_d = '0;
                    tout_d     = force_release;
                    state_d    = ST_TURN;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == TW'(TURN - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; last resets to M-1 so requester 0 goes first.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            bus_en_q   <= 1'b0;
            last_q     <= LW'(M - 1);
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            bus_en_q   <= bus_en_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            tout_q     <= tout_d;
        end
    end

    // Select the owner's data slice with a plain mux over all requesters.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < M; i++) begin
            if (last_q == LW'(i)) begin
                owner_data = bus.data_in[i*N +: N];
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.bus_en   = bus_en_q;
    assign bus.bus_data = bus_en_q ? owner_data : '0;
    assign bus.tout     = tout_q;

endmodule
